// File: rtl/mpu_pkg.sv
// Shared definitions for the matrix elementwise unit: op encoding, FSM states,
// and the beat-count helper.
package mpu_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_ADDS = 2'd2,
    OP_SUBS = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int beats(input int n, input int lanes);
    return (n + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/mpu_lane_alu.sv
// One element of the elementwise unit: signed add/sub with wrap or saturation,
// plus signed-overflow flag of the exact result.
module mpu_lane_alu
  import mpu_pkg::*;
#(
  parameter int ELEM_W = 8
) (
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  input  logic [1:0]        op,
  output logic [ELEM_W-1:0] r,
  output logic              ovf
);

  logic [ELEM_W:0] ax, bx, sum;
  logic            sub, sat;

  always_comb begin
    sub = (op == OP_SUB)  || (op == OP_SUBS);
    sat = (op == OP_ADDS) || (op == OP_SUBS);
    ax  = {a[ELEM_W-1], a};
    bx  = {b[ELEM_W-1], b};
    // One extra bit holds the exact result of any two ELEM_W-bit operands.
    sum = sub ? (ax - bx) : (ax + bx);
    ovf = sum[ELEM_W] ^ sum[ELEM_W-1];
    r   = sum[ELEM_W-1:0];
    if (sat && ovf)
      r = sum[ELEM_W] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}};
  end

endmodule

// File: rtl/mpu_elementwise.sv
// Matrix elementwise add/sub: operands latched on start, LANES elements
// written per beat, done pulse after the last beat.
module mpu_elementwise
  import mpu_pkg::*;
#(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5,
  parameter int LANES  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                op,
  input  logic [ELEM_W*DIM*DIM-1:0] matrix_a,
  input  logic [ELEM_W*DIM*DIM-1:0] matrix_b,
  output logic                      busy,
  output logic                      done,
  output logic [ELEM_W*DIM*DIM-1:0] result,
  output logic                      overflow
);

  localparam int N  = DIM * DIM;
  localparam int B  = beats(N, LANES);
  localparam int CW = (B > 1) ? $clog2(B) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(B - 1);

  typedef logic [N-1:0][ELEM_W-1:0] mat_t;

  state_e      state_q, state_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [1:0]  op_q, op_d;
  mat_t        a_q, a_d, b_q, b_d, res_q, res_d;
  logic        ovf_q, ovf_d;

  logic [LANES-1:0][ELEM_W-1:0] la, lb, lr;
  logic [LANES-1:0][NW-1:0]     lidx;
  logic [LANES-1:0]             lo, lv;

  // Lanes past the last element (partial final beat) are masked off by lv.
  always_comb begin
    int e;
    e = 0;
    for (int l = 0; l < LANES; l++) begin
      e       = int'(beat_q) * LANES + l;
      lv[l]   = (e < N);
      lidx[l] = NW'(e);
      la[l]   = lv[l] ? a_q[lidx[l]] : '0;
      lb[l]   = lv[l] ? b_q[lidx[l]] : '0;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mpu_lane_alu #(.ELEM_W(ELEM_W)) u_alu (
      .a  (la[l]),
      .b  (lb[l]),
      .op (op_q),
      .r  (lr[l]),
      .ovf(lo[l])
    );
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        beat_d  = '0;
        op_d    = op;
        a_d     = matrix_a;
        b_d     = matrix_b;
        ovf_d   = 1'b0;
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          if (lv[l]) begin
            res_d[lidx[l]] = lr[l];
            ovf_d          = ovf_d | lo[l];
          end
        end
        if (beat_q == LAST) begin
          state_d = DONE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign result   = res_q;
  assign overflow = ovf_q;

endmodule

// File: doc/mpu_elementwise.md
MPU_ELEMENTWISE -- requirements
Module: mpu_elementwise

Interface
REQ-001 SHALL have parameter ELEM_W, default 8: element width in bits, two's complement.
REQ-002 SHALL have parameter DIM, default 5: square matrix dimension; N = DIM*DIM elements.
REQ-003 SHALL have parameter LANES, default 5: elements processed per cycle, 1 <= LANES <= N.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  request a new operation.
REQ-007 SHALL have port op  input  2  operation select, sampled on accepted start.
REQ-008 SHALL have port matrix_a  input  ELEM_W*N  flattened matrix A, sampled on accepted start.
REQ-009 SHALL have port matrix_b  input  ELEM_W*N  flattened matrix B, sampled on accepted start.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when result is complete.
REQ-012 SHALL have port result  output  ELEM_W*N  flattened result matrix, registered.
REQ-013 SHALL have port overflow  output  1  any element signed-overflowed in the last operation.

Function
REQ-014 Element (i,j) SHALL occupy bits [ELEM_W*(i+DIM*j) +: ELEM_W] in matrix_a, matrix_b and result.
REQ-015 op encoding SHALL be: 0 ADD wrap, 1 SUB (a-b) wrap, 2 ADD signed-saturating, 3 SUB signed-saturating.
REQ-016 Saturating modes SHALL clamp to +(2^(ELEM_W-1)-1) or -(2^(ELEM_W-1)); wrap modes SHALL keep low ELEM_W bits.
REQ-017 Per-element overflow SHALL be signed overflow of the exact result, independent of mode; overflow output = OR over all N elements, cleared on accepted start.
REQ-018 FSM states SHALL be IDLE, RUN, DONE.
REQ-019 start SHALL be accepted only in IDLE; accepted start latches op, matrix_a, matrix_b, clears beat counter and overflow, enters RUN next cycle.
REQ-020 start SHALL be ignored in RUN and DONE; latched operands SHALL not change.
REQ-021 In RUN, beat k (k = 0..B-1, B = ceil(N/LANES)) SHALL write elements k*LANES .. k*LANES+LANES-1 into result; lanes with index >= N SHALL be ignored.
REQ-022 After beat B-1 the FSM SHALL enter DONE; DONE lasts exactly one cycle with done=1, then IDLE.
REQ-023 Start accepted at cycle 0 SHALL give done=1 at cycle B+1; busy=1 in cycles 1..B+1.
REQ-024 Elements not yet rewritten SHALL hold prior values; result is valid only from the done cycle until the next accepted start.
REQ-025 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted (back-to-back throughput B+2 cycles).

Reset
REQ-026 rst_n low at a rising edge SHALL force IDLE, beat counter 0, busy 0, done 0, overflow 0, result all zeros, from any state including mid-RUN.
REQ-027 start sampled while rst_n low SHALL be ignored.

Structure
REQ-028 Shared package mpu_pkg SHALL hold op encoding constants and the FSM state type.
REQ-029 Sub-module mpu_lane_alu SHALL compute one element (result, overflow) combinationally from a, b, op; instantiated LANES times.
REQ-030 Beat counter width SHALL be $clog2(B) with minimum 1 bit.

Verification (defaults unless noted)
REQ-031 op=0, A=1..25, B=25..1 -> all elements 26, overflow 0, done at cycle 6.
REQ-032 Element 0: A=127, B=1 -> op=0 gives 8'h80, op=2 gives 8'h7F; overflow 1 both.
REQ-033 Element 0: A=-128, B=1 -> op=1 gives 8'h7F, op=3 gives 8'h80; overflow 1 both; all-other-zero elements stay 0.
REQ-034 start pulsed again at cycles 2 and 6 with different operands -> ignored; result matches first operands; new start at cycle 7 accepted.
REQ-035 rst_n low during RUN beat 2 -> next cycle busy 0, done 0, result 0; subsequent start completes correctly.
REQ-036 LANES=4 -> B=7, done at cycle 8, element 24 correct (partial last beat), elements 25..27 absent.
